decod_morse: RTL and testbench

- Receive-side counterpart of the digit Morse encoder: samples a single keyed line and times each press as dot or dash.
- Collects five symbols per character, then decodes them back to a BCD digit 0-9.
- Sits between the key/button input and the display logic.
- Symbol encoding matches the encoder and demux: morse[i] is the i-th symbol sent; 1 = dot (ponto), 0 = dash (traco).

---
 rtl/decod_morse_if.sv | 25 ++
 rtl/decod_morse.sv | 155 +++++++++++++++
 tb/tb_decod_morse.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/decod_morse_if.sv
// Key-side and display-side signal bundle for the Morse digit decoder.
// The master drives the key and the slave returns the decoded digit.
interface decod_morse_if;
  logic       key;
  logic [3:0] num;
  logic [4:0] morse;
  logic       ready;
  logic       error;

  modport master (
    output key,
    input  num,
    input  morse,
    input  ready,
    input  error
  );

  modport slave (
    input  key,
    output num,
    output morse,
    output ready,
    output error
  );
endinterface

// File: rtl/decod_morse.sv
// Morse digit decoder: times key marks as dot/dash and collects five
// symbols per character, then decodes the pattern to a BCD digit.
module decod_morse #(
  parameter int DOT_MAX    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key,
  output logic [3:0] num,
  output logic [4:0] morse,
  output logic       ready,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    DECODE
  } state_t;

  localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic             key_m_q, key_s_q;
  logic [CNT_W-1:0] mark_q, mark_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [2:0]       idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       pat_q, pat_d;
  logic [3:0]       num_q, num_d;
  logic [4:0]       morse_q, morse_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  logic       legal;
  logic [3:0] dig;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_m_q <= 1'b0;
      key_s_q <= 1'b0;
      state_q <= IDLE;
      mark_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      pat_q   <= '0;
      num_q   <= '0;
      morse_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      key_m_q <= key;
      key_s_q <= key_m_q;
      state_q <= state_d;
      mark_q  <= mark_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      pat_q   <= pat_d;
      num_q   <= num_d;
      morse_q <= morse_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Legal patterns are runs of dots from one end and dashes from the other.
  always_comb begin
    legal = 1'b1;
    dig   = 4'd0;
    case (pat_q)
      5'b00001: dig = 4'd1;
      5'b00011: dig = 4'd2;
      5'b00111: dig = 4'd3;
      5'b01111: dig = 4'd4;
      5'b11111: dig = 4'd5;
      5'b11110: dig = 4'd6;
      5'b11100: dig = 4'd7;
      5'b11000: dig = 4'd8;
      5'b10000: dig = 4'd9;
      5'b00000: dig = 4'd0;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mark_d  = mark_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    pat_d   = pat_q;
    num_d   = num_q;
    morse_d = morse_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d = MARK;
          mark_d  = ONE;
          idx_d   = '0;
          pat_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      MARK: begin
        if (key_s_q) begin
          if (mark_q != '1) mark_d = mark_q + ONE;
        end else begin
          if (idx_q < 3'd5) begin
            pat_d[idx_q] = (mark_q <= DOT_LIM);
            idx_d        = idx_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          gap_d   = ONE;
          state_d = (GAP_LIM == ONE) ? DECODE : SPACE;
        end
      end
      SPACE: begin
        if (key_s_q) begin
          state_d = MARK;
          mark_d  = ONE;
        end else begin
          gap_d = gap_q + ONE;
          if (gap_d == GAP_LIM) state_d = DECODE;
        end
      end
      DECODE: begin
        morse_d = pat_q;
        state_d = IDLE;
        if (idx_q == 3'd5 && !ovf_q && legal) begin
          num_d   = dig;
          ready_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign num   = num_q;
  assign morse = morse_q;
  assign ready = ready_q;
  assign error = error_q;

endmodule

// File: tb/tb_decod_morse.sv
// Bench for decod_morse: table of keyed characters with a scoreboard of
// expected decode results, plus reset and gap-boundary sequences.
module tb_decod_morse;

  logic clock;
  logic reset;

  decod_morse_if bus ();

  decod_morse dut (
    .clock (clock),
    .reset (reset),
    .key   (bus.key),
    .num   (bus.num),
    .morse (bus.morse),
    .ready (bus.ready),
    .error (bus.error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         n;
    logic [5:0] s;
    int         dl;
    int         hl;
    int         gp;
    logic       ok;
    logic [3:0] dig;
    logic [4:0] m;
  } vec_t;

  typedef struct {
    logic       rdy;
    logic [3:0] num;
    logic [4:0] morse;
  } exp_t;

  exp_t       sbq[$];
  vec_t       tbl[17];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] last_num = 4'd0;
  logic       prev_pulse = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every ready/error pulse must match the oldest expectation.
  always @(posedge clock) begin
    #1;
    if (bus.ready || bus.error) begin
      vectors++;
      if (prev_pulse) begin
        miscompares++;
        $display("FAIL pulse_width: pulse held more than one cycle");
      end else if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: ready=%0b error=%0b morse=%b",
                 bus.ready, bus.error, bus.morse);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.ready !== e.rdy || bus.error !== !e.rdy ||
            bus.num !== e.num || bus.morse !== e.morse) begin
          miscompares++;
          $display("FAIL decode: got r=%0b e=%0b num=%0d morse=%b expected r=%0b e=%0b num=%0d morse=%b",
                   bus.ready, bus.error, bus.num, bus.morse,
                   e.rdy, !e.rdy, e.num, e.morse);
        end
      end
    end
    prev_pulse = bus.ready || bus.error;
  end

  task automatic idle(input int c);
    bus.key = 1'b0;
    repeat (c) @(negedge clock);
  endtask

  task automatic syms(input int n, input logic [5:0] s,
                      input int dl, input int hl, input int gp);
    for (int i = 0; i < n; i++) begin
      bus.key = 1'b1;
      repeat (s[i] ? dl : hl) @(negedge clock);
      bus.key = 1'b0;
      if (i != n - 1) repeat (gp) @(negedge clock);
    end
  endtask

  task automatic expect_res(input logic ok, input logic [3:0] dig,
                            input logic [4:0] m);
    exp_t e;
    e.rdy = ok;
    if (ok) last_num = dig;
    e.num   = last_num;
    e.morse = m;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    idle(16);
    while (sbq.size() != 0 && c < 40) begin
      @(negedge clock);
      c++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, %0d results missing", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic send(input vec_t v);
    expect_res(v.ok, v.dig, v.m);
    syms(v.n, v.s, v.dl, v.hl, v.gp);
    drain("char");
  endtask

  initial begin
    tbl[0]  = '{5, 6'b000000, 3, 8, 3, 1'b1, 4'd0, 5'b00000};
    tbl[1]  = '{5, 6'b000001, 3, 8, 3, 1'b1, 4'd1, 5'b00001};
    tbl[2]  = '{5, 6'b000011, 3, 8, 3, 1'b1, 4'd2, 5'b00011};
    tbl[3]  = '{5, 6'b000111, 3, 8, 3, 1'b1, 4'd3, 5'b00111};
    tbl[4]  = '{5, 6'b001111, 3, 8, 3, 1'b1, 4'd4, 5'b01111};
    tbl[5]  = '{5, 6'b011111, 3, 8, 3, 1'b1, 4'd5, 5'b11111};
    tbl[6]  = '{5, 6'b011110, 3, 8, 3, 1'b1, 4'd6, 5'b11110};
    tbl[7]  = '{5, 6'b011100, 3, 8, 3, 1'b1, 4'd7, 5'b11100};
    tbl[8]  = '{5, 6'b011000, 3, 8, 3, 1'b1, 4'd8, 5'b11000};
    tbl[9]  = '{5, 6'b010000, 3, 8, 3, 1'b1, 4'd9, 5'b10000};
    tbl[10] = '{5, 6'b000111, 4, 5, 3, 1'b1, 4'd3, 5'b00111};
    tbl[11] = '{5, 6'b011000, 1, 5, 1, 1'b1, 4'd8, 5'b11000};
    tbl[12] = '{5, 6'b011110, 3, 8, 7, 1'b1, 4'd6, 5'b11110};
    tbl[13] = '{5, 6'b010000, 3, 300, 3, 1'b1, 4'd9, 5'b10000};
    tbl[14] = '{3, 6'b000111, 3, 8, 3, 1'b0, 4'd0, 5'b00111};
    tbl[15] = '{6, 6'b100111, 3, 8, 3, 1'b0, 4'd0, 5'b00111};
    tbl[16] = '{5, 6'b001010, 3, 8, 3, 1'b0, 4'd0, 5'b01010};

    reset   = 1'b0;
    bus.key = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.key = ~bus.key;
    end
    chk("rst_num", int'(bus.num), 0);
    chk("rst_morse", int'(bus.morse), 0);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_error", int'(bus.error), 0);
    bus.key = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    idle(4);

    foreach (tbl[i]) send(tbl[i]);

    // An 8-cycle gap inside a character splits it into two bad characters.
    expect_res(1'b0, 4'd0, 5'b00011);
    syms(2, 6'b000011, 3, 8, 3);
    idle(8);
    expect_res(1'b0, 4'd0, 5'b00000);
    syms(3, 6'b000000, 3, 8, 3);
    drain("gap8");
    chk("gap8_num", int'(bus.num), int'(last_num));

    // Reset in the middle of a character: no pulse, outputs cleared.
    syms(2, 6'b000011, 3, 8, 3);
    idle(2);
    reset = 1'b0;
    #1;
    chk("mid_rst_num", int'(bus.num), 0);
    chk("mid_rst_morse", int'(bus.morse), 0);
    chk("mid_rst_ready", int'(bus.ready), 0);
    chk("mid_rst_error", int'(bus.error), 0);
    last_num = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.key = ~bus.key;
    end
    bus.key = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    idle(20);
    chk("post_rst_num", int'(bus.num), 0);
    send(tbl[7]);
    chk("final_num", int'(bus.num), 7);
    chk("final_morse", int'(bus.morse), 5'b11100);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
